// File: rtl/game_pkg.sv
// game_pkg: VGA 800x600@72 timing, colours, platform record and hit helper for game_renderer
package game_pkg;
   localparam int H_ACTIVE = 800;
   localparam int H_FP = 56;
   localparam int H_SYNC = 120;
   localparam int H_TOTAL = 1040;
   localparam int V_ACTIVE = 600;
   localparam int V_FP = 37;
   localparam int V_SYNC = 6;
   localparam int V_TOTAL = 666;
   localparam int BALL_R = 20;
   localparam int PLAT_H = 8;
   localparam int HOR_SCALE_LOG2 = 3;
   localparam logic [7:0] COL_BG = 8'hDB;
   localparam logic [7:0] COL_BALL = 8'hE0;
   localparam logic [7:0] COL_PLAT = 8'h1C;
   localparam logic [7:0] COL_OVER = 8'hA0;

   typedef struct packed {
      logic [9:0] ver;
      logic [6:0] hor;
      logic [5:0] width;
   } plat_t;

   // a negative left bound (sign bit set) clips to column 0
   function automatic logic plat_hit(plat_t p, logic [10:0] h, logic [9:0] v);
      logic [11:0] l, r;
      l = ({5'b0, p.hor} - {6'b0, p.width}) << HOR_SCALE_LOG2;
      r = ({5'b0, p.hor} + {6'b0, p.width}) << HOR_SCALE_LOG2;
      return (l[11] || {1'b0, h} >= l) && {1'b0, h} <= r &&
             v >= p.ver && {1'b0, v} < {1'b0, p.ver} + 11'(PLAT_H);
   endfunction
endpackage

// File: rtl/game_renderer_vga_timing.sv
// vga_timing: hcnt/vcnt counters, active flag, raw syncs and snapshot strobe
module vga_timing
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] hcnt,
   output logic [9:0]  vcnt,
   output logic        active,
   output logic        hsync,
   output logic        vsync,
   output logic        snap
);
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         hcnt <= hcnt == 11'(H_TOTAL - 1) ? '0 : hcnt + 11'd1;
         if (hcnt == 11'(H_TOTAL - 1))
            vcnt <= vcnt == 10'(V_TOTAL - 1) ? '0 : vcnt + 10'd1;
      end
   end

   assign active = hcnt < 11'(H_ACTIVE) && vcnt < 10'(V_ACTIVE);
   assign hsync = hcnt >= 11'(H_ACTIVE + H_FP) && hcnt < 11'(H_ACTIVE + H_FP + H_SYNC);
   assign vsync = vcnt >= 10'(V_ACTIVE + V_FP) && vcnt < 10'(V_ACTIVE + V_FP + V_SYNC);
   assign snap = hcnt == '0 && vcnt == 10'(V_ACTIVE);
endmodule

// File: rtl/game_renderer.sv
// game_renderer: snapshot + 2-stage rasteriser of ball/platforms to VGA RGB332; GAME_OVER_OVERLAY_EN enables over
module game_renderer
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] ball_ver,
   input  logic [6:0] ball_hor,
   input  logic [9:0] platform0_ver,
   input  logic [6:0] platform0_hor,
   input  logic [5:0] platform0_width,
   input  logic [9:0] platform1_ver,
   input  logic [6:0] platform1_hor,
   input  logic [5:0] platform1_width,
   input  logic [9:0] platform2_ver,
   input  logic [6:0] platform2_hor,
   input  logic [5:0] platform2_width,
   input  logic [6:0] platform3_ver,
   input  logic [6:0] platform3_hor,
   input  logic [5:0] platform3_width,
   input  logic [9:0] out_platform_ver,
   input  logic [6:0] out_platform_hor,
   input  logic [5:0] out_platform_width,
   input  logic       over,
   output logic       hsync,
   output logic       vsync,
   output logic [7:0] rgb,
   output logic       frame_start
);
   logic [10:0] hcnt;
   logic [9:0] vcnt;
   logic active, hs_raw, vs_raw, snap;

   vga_timing u_timing (
      .clk(clk),
      .rst(rst),
      .hcnt(hcnt),
      .vcnt(vcnt),
      .active(active),
      .hsync(hs_raw),
      .vsync(vs_raw),
      .snap(snap)
   );

   logic [9:0] ball_ver_s;
   logic [6:0] ball_hor_s;
   plat_t [4:0] plat_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         ball_ver_s <= '0;
         ball_hor_s <= '0;
         plat_s <= '0;
      end else if (snap) begin
         ball_ver_s <= ball_ver;
         ball_hor_s <= ball_hor;
         plat_s <= {plat_t'{out_platform_ver, out_platform_hor, out_platform_width},
                    plat_t'{{3'b0, platform3_ver}, platform3_hor, platform3_width},
                    plat_t'{platform2_ver, platform2_hor, platform2_width},
                    plat_t'{platform1_ver, platform1_hor, platform1_width},
                    plat_t'{platform0_ver, platform0_hor, platform0_width}};
      end
   end

   logic over_s;
   logic [7:0] bg;
`ifdef GAME_OVER_OVERLAY_EN
   always_ff @(posedge clk) begin
      if (rst)
         over_s <= 1'b0;
      else if (snap)
         over_s <= over;
   end
   assign bg = over_s ? COL_OVER : COL_BG;
`else
   logic unused_over;
   assign unused_over = over;
   assign over_s = 1'b0;
   assign bg = COL_BG;
`endif

   logic signed [11:0] dx, dy;
   logic signed [23:0] d2;
   logic ball_hit, plat_any;

   assign dx = $signed({1'b0, hcnt} - (12'(ball_hor_s) << HOR_SCALE_LOG2));
   assign dy = $signed({2'b0, vcnt} - {2'b0, ball_ver_s});
   assign d2 = dx * dx + dy * dy;
   assign ball_hit = d2 <= $signed(24'(BALL_R * BALL_R)) && !over_s;

   always_comb begin
      plat_any = 1'b0;
      for (int i = 0; i < 5; i++)
         plat_any = plat_any | plat_hit(plat_s[i], hcnt, vcnt);
   end

   logic s1_active, s1_hs, s1_vs, s1_ball, s1_plat;

   always_ff @(posedge clk) begin
      if (rst) begin
         {s1_active, s1_hs, s1_vs, s1_ball, s1_plat} <= '0;
         {hsync, vsync, rgb} <= '0;
      end else begin
         {s1_active, s1_hs, s1_vs, s1_ball, s1_plat} <= {active, hs_raw, vs_raw, ball_hit, plat_any};
         hsync <= s1_hs;
         vsync <= s1_vs;
         rgb <= !s1_active ? 8'h00 : s1_ball ? COL_BALL : s1_plat ? COL_PLAT : bg;
      end
   end

   assign frame_start = snap;
endmodule

// File: tb/tb_game_renderer.sv
// tb_game_renderer: directed checks of timing, snapshot, disc/platform raster, priority and reset
module tb_game_renderer;
   localparam logic [7:0] BG = 8'hDB, BALL = 8'hE0, PLAT = 8'h1C;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [9:0] ball_ver = '0;
   logic [6:0] ball_hor = '0;
   logic [9:0] p0_ver = '0, p1_ver = '0, p2_ver = '0, op_ver = '0;
   logic [6:0] p3_ver = '0;
   logic [6:0] p0_hor = '0, p1_hor = '0, p2_hor = '0, p3_hor = '0, op_hor = '0;
   logic [5:0] p0_w = '0, p1_w = '0, p2_w = '0, p3_w = '0, op_w = '0;
   logic over = 1'b0;
   logic hsync, vsync, frame_start;
   logic [7:0] rgb;

   game_renderer dut (
      .clk(clk), .rst(rst),
      .ball_ver(ball_ver), .ball_hor(ball_hor),
      .platform0_ver(p0_ver), .platform0_hor(p0_hor), .platform0_width(p0_w),
      .platform1_ver(p1_ver), .platform1_hor(p1_hor), .platform1_width(p1_w),
      .platform2_ver(p2_ver), .platform2_hor(p2_hor), .platform2_width(p2_w),
      .platform3_ver(p3_ver), .platform3_hor(p3_hor), .platform3_width(p3_w),
      .out_platform_ver(op_ver), .out_platform_hor(op_hor), .out_platform_width(op_w),
      .over(over), .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
   );

   always #10 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int ph = 0, pv = 0, ph1h = 1039, ph1v = 665, ph2h = 1039, ph2v = 665;
   longint cyc = 0, h_last = 0, v_last = 0;
   longint h_period = 0, h_high = 0, v_period = 0, v_high = 0;
   logic prev_hs = 1'b0, prev_vs = 1'b0;
   int blank_bad = 0, fs_count = 0, fs_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // ph/pv track the counter value the DUT holds after each edge; ph2 is the pixel now on rgb
   task automatic step();
      @(posedge clk);
      cyc++;
      if (rst) begin
         ph = 0; pv = 0; ph1h = 1039; ph1v = 665; ph2h = 1039; ph2v = 665;
      end else begin
         ph2h = ph1h; ph2v = ph1v; ph1h = ph; ph1v = pv;
         if (ph == 1039) begin
            ph = 0;
            pv = pv == 665 ? 0 : pv + 1;
         end else ph = ph + 1;
      end
      #1;
      if ((ph2h >= 800 || ph2v >= 600) && rgb !== 8'h00) blank_bad++;
      if (frame_start) begin
         fs_count++;
         if (!(ph == 0 && pv == 600)) fs_bad++;
      end
      if (hsync && !prev_hs) begin
         if (h_last != 0) h_period = cyc - h_last;
         h_last = cyc;
      end
      if (!hsync && prev_hs) h_high = cyc - h_last;
      if (vsync && !prev_vs) begin
         if (v_last != 0) v_period = cyc - v_last;
         v_last = cyc;
      end
      if (!vsync && prev_vs) v_high = cyc - v_last;
      prev_hs = hsync;
      prev_vs = vsync;
   endtask

   task automatic wait_pos(input int h, input int v);
      int n = 0;
      while (!(ph == h && pv == v) && n < 800000) begin step(); n++; end
      if (n >= 800000) begin n_fail++; $display("FAIL timeout waiting for (%0d,%0d)", h, v); end
   endtask

   task automatic check_px(input int x, input int y, input logic [7:0] exp, input string tag);
      int n = 0;
      while (!(ph2h == x && ph2v == y) && n < 800000) begin step(); n++; end
      if (n >= 800000) begin n_fail++; $display("FAIL timeout waiting for pixel (%0d,%0d)", x, y); end
      chk(tag, rgb, exp);
   endtask

   initial begin
      step(); step();
      rst = 1'b0;
      chk("reset_rgb", rgb, 8'h00);
      chk("reset_hsync", hsync, 1'b0);
      chk("reset_vsync", vsync, 1'b0);
      chk("reset_frame_start", frame_start, 1'b0);
      // zero shadows: quarter disc at the origin
      check_px(20, 0, BALL, "f0_ball_20_0");
      check_px(21, 0, BG, "f0_bg_21_0");
      wait_pos(857, 1); chk("hsync_pre", hsync, 1'b0);
      wait_pos(858, 1); chk("hsync_rise", hsync, 1'b1);
      wait_pos(977, 1); chk("hsync_last", hsync, 1'b1);
      wait_pos(978, 1); chk("hsync_fall", hsync, 1'b0);
      check_px(0, 10, BALL, "f0_ball_0_10");
      ball_hor = 7'd50; ball_ver = 10'd300;
      p0_hor = 7'd2; p0_w = 6'd10; p0_ver = 10'd200;
      p1_hor = 7'd20; p1_w = 6'd10; p1_ver = 10'd376;
      p3_hor = 7'd10; p3_w = 6'd4; p3_ver = 7'd100;
      op_hor = 7'd100; op_w = 6'd5; op_ver = 10'd500;
      wait_pos(0, 600); chk("frame_start_pulse", frame_start, 1'b1);
      wait_pos(1, 600); chk("frame_start_low", frame_start, 1'b0);
      wait_pos(1, 637); chk("vsync_pre", vsync, 1'b0);
      wait_pos(2, 637); chk("vsync_rise", vsync, 1'b1);
      wait_pos(1, 643); chk("vsync_last", vsync, 1'b1);
      wait_pos(2, 643); chk("vsync_fall", vsync, 1'b0);
      chk("vsync_high_cycles", 32'(v_high), 32'd6240);
      // frame 1
      check_px(47, 100, BG, "p3_left_out");
      check_px(48, 100, PLAT, "p3_left_edge");
      wait_pos(100, 100);
      ball_ver = 10'd310;
      check_px(0, 200, PLAT, "clip_x0");
      check_px(96, 200, PLAT, "clip_right");
      check_px(97, 200, BG, "clip_right_out");
      check_px(0, 207, PLAT, "clip_last_row");
      check_px(0, 208, BG, "clip_below");
      check_px(400, 280, BALL, "ball_top");
      check_px(400, 300, BALL, "ball_centre");
      check_px(420, 300, BALL, "ball_right_edge");
      check_px(421, 300, BG, "ball_right_out");
      check_px(415, 315, BG, "ball_diag_out");
      check_px(400, 320, BALL, "ball_bottom_old");
      check_px(79, 376, BG, "p1_left_out");
      check_px(80, 376, PLAT, "p1_left_edge");
      check_px(241, 376, BG, "p1_right_out");
      check_px(240, 383, PLAT, "p1_right_last_row");
      check_px(80, 384, BG, "p1_below");
      check_px(759, 500, BG, "outp_left_out");
      check_px(760, 500, PLAT, "outp_left_edge");
      wait_pos(1, 600); chk("fs_count_f1", fs_count, 2);
      wait_pos(3, 637); chk("vsync_period", 32'(v_period), 32'd692640);
      // frame 2: ball moved to 310
      check_px(400, 280, BG, "new_ball_old_top");
      check_px(400, 289, BG, "new_ball_above");
      check_px(400, 290, BALL, "new_ball_top");
      check_px(400, 330, BALL, "new_ball_bottom");
      check_px(400, 331, BG, "new_ball_below");
      wait_pos(0, 400);
      ball_ver = 10'd380; p1_hor = 7'd50;
`ifdef GAME_OVER_OVERLAY_EN
      chk("pre_overlay", 32'(over), 32'd0);
`endif
      chk("hsync_period", 32'(h_period), 32'd1040);
      chk("hsync_high", 32'(h_high), 32'd120);
      chk("blank_rgb_zero", blank_bad, 0);
      wait_pos(1, 600);
      chk("fs_count_f2", fs_count, 3);
      chk("fs_position", fs_bad, 0);
      // frame 3: ball over platform
      check_px(400, 376, BALL, "prio_overlap_top");
      check_px(330, 378, PLAT, "prio_plat_only");
      check_px(481, 378, BG, "prio_plat_right_out");
      check_px(400, 383, BALL, "prio_overlap_bottom");
`ifdef GAME_OVER_OVERLAY_EN
      over = 1'b1;
      check_px(10, 10, 8'hA0, "overlay_bg");
      check_px(400, 380, PLAT, "overlay_no_ball_plat");
      check_px(400, 395, 8'hA0, "overlay_no_ball");
`endif
      wait_pos(500, 450);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_rgb0", rgb, 8'h00);
      chk("rst_hsync", hsync, 1'b0);
      chk("rst_vsync", vsync, 1'b0);
      chk("rst_frame_start", frame_start, 1'b0);
      step();
      chk("rst_rgb1", rgb, 8'h00);
      step();
      chk("rst_pixel_origin", rgb, BALL);
      check_px(21, 0, BG, "rst_shadow_clear");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
